// File: rtl/pio_pkg.sv
// Shared constants for the PIO FIFO blocks: word width, default depth and
// the bit positions of the sticky status flags.
package pio_pkg;

    localparam int PIO_WORD_W = 32;
    localparam int TX_DEPTH   = 4;

    localparam int FLAG_W     = 2;
    localparam int FLAG_OVER  = 0;
    localparam int FLAG_UNDER = 1;

    typedef logic [FLAG_W-1:0] pio_flags_t;

endpackage

// File: rtl/pio_fifo_core.sv
// FIFO storage, pointers and occupancy shared by the TX and RX FIFOs.
// Capacity is DEPTH or 2*DEPTH; pointers wrap at the active capacity.
module pio_fifo_core
    import pio_pkg::*;
#(
    parameter int  WIDTH = PIO_WORD_W,
    parameter int  DEPTH = TX_DEPTH,
    localparam int PTR_W = $clog2(2*DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             join_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             wr_en_i,
    input  logic             rd_ack_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] cap;
    logic [WIDTH-1:0] mem_q [2*DEPTH];
    logic             wr_accept;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                                 input logic [LVL_W-1:0] c);
        if (LVL_W'(p) == c - 1'b1)
            return '0;
        return p + 1'b1;
    endfunction

    assign cap     = join_i ? LVL_W'(2*DEPTH) : LVL_W'(DEPTH);
    assign full_o  = (level_q == cap);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

    // A write into a full FIFO is only legal because the same edge pops a slot.
    assign wr_accept = wr_en_i && (!full_o || rd_ack_i) && !flush_i;
    assign pop       = rd_ack_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_accept)
                wr_ptr_d = ptr_inc(wr_ptr_q, cap);
            if (pop)
                rd_ptr_d = ptr_inc(rd_ptr_q, cap);
            level_d = level_q + LVL_W'(wr_accept) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && wr_accept)
            mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/tx_fifo.sv
// Transmit FIFO feeding the output shift register: FIFO core plus sticky
// overflow/underflow flags and the flush applied when the join mode changes.
module tx_fifo
    import pio_pkg::*;
#(
    parameter int  WIDTH = PIO_WORD_W,
    parameter int  DEPTH = TX_DEPTH,
    localparam int LVL_W = $clog2(2*DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    output logic             full,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    input  logic             rd_ack,
    input  logic             join_en,
    output logic [LVL_W-1:0] level,
    output logic             over_flag,
    output logic             under_flag,
    input  pio_flags_t       flag_clr
);

    logic join_q;
    logic over_q, over_d;
    logic under_q, under_d;
    logic flush;
    logic over_set;
    logic under_set;

    assign flush = (join_en != join_q);

    pio_fifo_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .clk_i     (clk),
        .rst_ni    (rst),
        .flush_i   (flush),
        .join_i    (join_q),
        .wr_data_i (wr_data),
        .wr_en_i   (wr_en),
        .rd_ack_i  (rd_ack),
        .rd_data_o (rd_data),
        .full_o    (full),
        .empty_o   (empty),
        .level_o   (level)
    );

    // Flush cycles discard traffic, so they raise no error flags either.
    assign over_set  = wr_en && full && !rd_ack && !flush;
    assign under_set = rd_ack && empty && !flush;

    always_comb begin
        over_d  = over_set  || (over_q  && !flag_clr[FLAG_OVER]);
        under_d = under_set || (under_q && !flag_clr[FLAG_UNDER]);
    end

    // join_q loads the live mode in reset so leaving reset never flushes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            join_q  <= join_en;
            over_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            join_q  <= join_en;
            over_q  <= over_d;
            under_q <= under_d;
        end
    end

    assign over_flag  = over_q;
    assign under_flag = under_q;

endmodule

// File: tb/tb_tx_fifo.sv
// Self-checking bench for tx_fifo: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_tx_fifo;
    import pio_pkg::*;

    localparam int W  = PIO_WORD_W;
    localparam int D  = TX_DEPTH;
    localparam int LW = $clog2(2*D) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  wr_data;
    logic          wr_en;
    logic          full;
    logic [W-1:0]  rd_data;
    logic          empty;
    logic          rd_ack;
    logic          join_en;
    logic [LW-1:0] level;
    logic          over_flag;
    logic          under_flag;
    logic [1:0]    flag_clr;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq[$];
    logic         m_join;
    logic         m_over;
    logic         m_under;

    always #5 clk = ~clk;

    tx_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .full       (full),
        .rd_data    (rd_data),
        .empty      (empty),
        .rd_ack     (rd_ack),
        .join_en    (join_en),
        .level      (level),
        .over_flag  (over_flag),
        .under_flag (under_flag),
        .flag_clr   (flag_clr)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a queue of words; capacity from the mode; flags set-wins-over-clear.
    task automatic model_edge();
        int  cap;
        bit  is_full, is_empty, ov, un, do_pop, do_wr;
        if (!rst) begin
            mq.delete();
            m_join  = join_en;
            m_over  = 1'b0;
            m_under = 1'b0;
        end else if (join_en != m_join) begin
            mq.delete();
            m_join  = join_en;
            m_over  = m_over  & ~flag_clr[0];
            m_under = m_under & ~flag_clr[1];
        end else begin
            cap      = m_join ? 2*D : D;
            is_full  = (mq.size() == cap);
            is_empty = (mq.size() == 0);
            ov       = wr_en && is_full && !rd_ack;
            un       = rd_ack && is_empty;
            do_pop   = rd_ack && !is_empty;
            do_wr    = wr_en && (!is_full || rd_ack);
            if (do_pop) void'(mq.pop_front());
            if (do_wr)  mq.push_back(wr_data);
            m_over  = ov | (m_over  & ~flag_clr[0]);
            m_under = un | (m_under & ~flag_clr[1]);
        end
    endtask

    task automatic check_all();
        int cap;
        cap = m_join ? 2*D : D;
        check_eq("level",   64'(level),      64'(mq.size()));
        check_eq("full",    64'(full),       64'(mq.size() == cap));
        check_eq("empty",   64'(empty),      64'(mq.size() == 0));
        check_eq("rd_data", 64'(rd_data),    (mq.size() == 0) ? 64'd0 : 64'(mq[0]));
        check_eq("over",    64'(over_flag),  64'(m_over));
        check_eq("under",   64'(under_flag), 64'(m_under));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic wr, input logic [W-1:0] d, input logic ack,
                         input logic [1:0] clr);
        wr_en    = wr;
        wr_data  = d;
        rd_ack   = ack;
        flag_clr = clr;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 2'b00);
    endtask

    initial begin
        rst = 1'b0;
        join_en = 1'b0;
        idle();
        m_join = 1'b0; m_over = 1'b0; m_under = 1'b0;

        // reset hold
        cycle();
        cycle();
        check_eq("rst_level", 64'(level), 64'd0);
        check_eq("rst_empty", 64'(empty), 64'd1);
        check_eq("rst_rdata", 64'(rd_data), 64'd0);
        rst = 1'b1;

        // fill to full, then overflow
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W'(32'hA + i), 1'b0, 2'b00);
            cycle();
        end
        check_eq("fill_full", 64'(full), 64'd1);
        check_eq("fill_level", 64'(level), 64'd4);
        check_eq("fill_head", 64'(rd_data), 64'hA);
        drive(1'b1, 32'hE, 1'b0, 2'b00);
        cycle();
        check_eq("ovf_flag", 64'(over_flag), 64'd1);
        check_eq("ovf_level", 64'(level), 64'd4);

        // drain, underflow, clear
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_data", 64'(rd_data), 64'(32'hA + i));
            drive(1'b0, '0, 1'b1, 2'b00);
            cycle();
        end
        check_eq("drain_empty", 64'(empty), 64'd1);
        check_eq("drain_rdata", 64'(rd_data), 64'd0);
        cycle();
        check_eq("udf_flag", 64'(under_flag), 64'd1);
        drive(1'b0, '0, 1'b0, 2'b11);
        cycle();
        check_eq("clr_over", 64'(over_flag), 64'd0);
        check_eq("clr_under", 64'(under_flag), 64'd0);

        // joined mode, two passes of 8 words
        idle();
        join_en = 1'b1;
        cycle();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 8; i++) begin
                check_eq("join_notfull", 64'(full), 64'd0);
                drive(1'b1, W'(32'h100 + 32'h100*pass + i), 1'b0, 2'b00);
                cycle();
            end
            check_eq("join_full", 64'(full), 64'd1);
            check_eq("join_level", 64'(level), 64'd8);
            for (int i = 0; i < 8; i++) begin
                check_eq("join_data", 64'(rd_data), 64'(32'h100 + 32'h100*pass + i));
                drive(1'b0, '0, 1'b1, 2'b00);
                cycle();
            end
        end

        // full with simultaneous write and pop
        idle();
        join_en = 1'b0;
        cycle();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, W'(i), 1'b0, 2'b00);
            cycle();
        end
        drive(1'b1, 32'h55, 1'b1, 2'b00);
        cycle();
        check_eq("fullrw_level", 64'(level), 64'd4);
        check_eq("fullrw_over", 64'(over_flag), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq("fullrw_data", 64'((i == 3) ? 32'h55 : 32'(i + 2)), 64'(rd_data));
            drive(1'b0, '0, 1'b1, 2'b00);
            cycle();
        end

        // empty with simultaneous write and pop
        drive(1'b1, 32'h77, 1'b1, 2'b00);
        cycle();
        check_eq("emptyrw_under", 64'(under_flag), 64'd1);
        check_eq("emptyrw_level", 64'(level), 64'd1);
        check_eq("emptyrw_data", 64'(rd_data), 64'h77);

        // join toggle flushes a partially filled FIFO
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, W'(32'hC0 + i), 1'b0, 2'b00);
            cycle();
        end
        check_eq("pre_flush_level", 64'(level), 64'd3);
        idle();
        join_en = 1'b1;
        cycle();
        check_eq("flush_level", 64'(level), 64'd0);
        check_eq("flush_empty", 64'(empty), 64'd1);
        check_eq("flush_keep_under", 64'(under_flag), 64'd1);

        // reset mid-stream with a write pending
        drive(1'b1, 32'hD0, 1'b0, 2'b00);
        cycle();
        drive(1'b1, 32'hD1, 1'b0, 2'b00);
        rst = 1'b0;
        cycle();
        check_eq("midrst_level", 64'(level), 64'd0);
        check_eq("midrst_under", 64'(under_flag), 64'd0);
        check_eq("midrst_over", 64'(over_flag), 64'd0);
        rst = 1'b1;
        idle();
        cycle();

        // randomized traffic with varying bias
        for (int i = 0; i < 3000; i++) begin
            int wr_bias, rd_bias;
            wr_bias = ((i / 200) % 3 == 0) ? 80 : (((i / 200) % 3 == 1) ? 30 : 55);
            rd_bias = 100 - wr_bias;
            drive(($urandom_range(0, 99) < wr_bias), $urandom,
                  ($urandom_range(0, 99) < rd_bias),
                  ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
            if ($urandom_range(0, 149) == 0) join_en = ~join_en;
            rst = ($urandom_range(0, 399) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_fifo.md
Name: tx_fifo

Overview:
- Transmit FIFO between the system bus write port and the output shift register's pull interface.
- Buffers 32-bit words written by the system; presents the head word to the OSR and pops it when the OSR acknowledges a pull.
- Supports joining the RX storage to double the depth, and reports sticky overflow/underflow flags and the fill level.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 4, entries in normal mode; 2*DEPTH entries when joined. Must be a power of two.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-low reset, sampled on rising edge of clk.
- wr_data  input  WIDTH  word from the system bus.
- wr_en  input  1  write strobe, one word per cycle.
- full  output  1  no free entry.
- rd_data  output  WIDTH  head word, first-word-fall-through; drives the OSR fifo_in.
- empty  output  1  no valid entry; the OSR stalls PULL / autopull while this is high.
- rd_ack  input  1  pop strobe; driven by the OSR fifo_pulled.
- join  input  1  1 = depth 2*DEPTH.
- level  output  clog2(2*DEPTH)+1  current occupancy, 0..2*DEPTH.
- over_flag  output  1  sticky: a write was attempted while full.
- under_flag  output  1  sticky: a pop was attempted while empty.
- flag_clr  input  2  write-1-to-clear: bit0 clears over_flag, bit1 clears under_flag.

Behaviour:
- Reset (rst=0 at edge): pointers=0, level=0, empty=1, full=0, over_flag=0, under_flag=0, rd_data=0. Storage contents are not cleared. Reset overrides every other input in that cycle.
- Capacity: CAP = join ? 2*DEPTH : DEPTH. full = (level==CAP). empty = (level==0).
- Storage: 2*DEPTH x WIDTH array. Write pointer and read pointer are clog2(2*DEPTH) bits and wrap modulo CAP.
- Write:
  - Accepted at the edge when wr_en=1 and (!full or rd_ack).
  - A write while full with no rd_ack is dropped and sets over_flag. Storage and pointers are unchanged.
- Pop:
  - Occurs at the edge when rd_ack=1 and !empty; the read pointer advances.
  - rd_ack while empty sets under_flag and changes nothing.
- Simultaneous write and pop:
  - While full: both take effect; level unchanged.
  - While empty: write accepted, pop is an underflow (flag set); level becomes 1.
  - Otherwise: both take effect; level unchanged.
- rd_data:
  - Combinational read of mem[rd_ptr] when !empty, else 0.
  - A word written at edge N is visible on rd_data during cycle N+1 if the FIFO was empty (write-to-read latency 1 cycle).
- level arithmetic: level_next = level + wr_accept - pop_accept. It never exceeds CAP and never underflows.
- Join change:
  - Any edge where join differs from its registered copy flushes the FIFO: pointers=0, level=0.
  - Writes and pops in that cycle are discarded; flags are unaffected.
- Flags:
  - flag_clr takes effect at the edge.
  - If a clear and a set occur for the same flag in one cycle, set wins.
- No combinational path from wr_en to rd_data/empty. full and empty are derived from registered level only.

Decomposition:
- Shared package pio_pkg: WIDTH constant (PIO_WORD_W=32), TX_DEPTH=4, flag bit indices (FLAG_OVER=0, FLAG_UNDER=1).
- The RX FIFO reuses the same core: factor a sub-module pio_fifo_core (storage, pointers, level, full/empty).
- tx_fifo wraps pio_fifo_core with the flag logic and join flush.

Test Plan:
- Reset hold, then write 0xA, 0xB, 0xC, 0xD with join=0 -> full=1 after the 4th edge, level=4, rd_data=0xA. 5th write of 0xE -> over_flag=1, level stays 4.
- Pop 4 times from the state above -> rd_data sequence 0xA, 0xB, 0xC, 0xD, then empty=1 and rd_data=0. A 5th rd_ack -> under_flag=1. flag_clr=2'b11 -> both flags 0 next cycle.
- join=1, write 8 words 0x100..0x107 -> full only after the 8th; level=8. Read back in order; pointers wrap correctly on a second pass of 8 words.
- Full FIFO (4 words), wr_en=1 and rd_ack=1 same cycle with 0x55 -> level stays 4, over_flag=0, 0x55 read out last.
- Empty FIFO, wr_en=1 (0x77) and rd_ack=1 same cycle -> under_flag=1, level=1, rd_data=0x77 next cycle.
- Level 3, toggle join 0->1 -> level=0, empty=1 next cycle. Assert rst=0 mid-stream with wr_en=1 -> level=0, flags=0, write discarded.
